// File: rtl/line_burst_adapter.sv
// Memory-side responder that turns one cacheline read/write request into a
// BEATS-long burst on the physical-memory port and pulses resp when done.
module line_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  resp,
  output logic [31:0]           burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        // Read wins when both requests are raised together.
        if (read) begin
          addr_d  = address & ALIGN_MASK;
          state_d = READ_BURST;
        end else if (write) begin
          addr_d  = address & ALIGN_MASK;
          wdata_d = wdata;
          state_d = WRITE_BURST;
        end
      end

      READ_BURST: begin
        if (burst_resp) begin
          rdata_d[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH] = burst_rdata;
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end

      WRITE_BURST: begin
        if (burst_resp) begin
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line registers are plain flops, not RAM, so clearing them in
  // reset is cheap and guarantees a reset mid-burst leaves no stale beats.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata         = rdata_q;
  assign resp          = (state_q == DONE);
  assign burst_read    = (state_q == READ_BURST);
  assign burst_write   = (state_q == WRITE_BURST);
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH];

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed self-checking bench for line_burst_adapter: reset, reads, writes
// with wait states, read priority, mid-burst reset and back-to-back requests.
module tb_line_burst_adapter;

  localparam int LW = 256;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   address;
  logic          read;
  logic          write;
  logic [LW-1:0] wdata;
  logic [LW-1:0] rdata;
  logic          resp;
  logic [31:0]   burst_address;
  logic          burst_read;
  logic          burst_write;
  logic [BW-1:0] burst_wdata;
  logic [BW-1:0] burst_rdata;
  logic          burst_resp;

  int tests_run = 0;
  int tests_failed = 0;

  line_burst_adapter #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .wdata         (wdata),
    .rdata         (rdata),
    .resp          (resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read request from raise to the IDLE cycle after resp. nwaits wait cycles
  // are inserted before beat wait_beat; also_write raises write as well.
  task automatic run_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [LW-1:0] line,
                          input int wait_beat, input int nwaits, input bit also_write);
    int cyc = 1;
    int resp_cnt = 0;
    int wr_cnt = 0;
    read = 1'b1; address = addr; burst_resp = 1'b0;
    if (also_write) begin
      write = 1'b1; wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    end
    do_cycle(); cyc++;
    check({tag, " burst_read"}, LW'(burst_read), LW'(1));
    check({tag, " burst_address"}, LW'(burst_address), LW'(exp_addr));
    for (int k = 0; k < 4; k++) begin
      if (k == wait_beat) begin
        for (int w = 0; w < nwaits; w++) begin
          resp_cnt += int'(resp); wr_cnt += int'(burst_write);
          burst_resp = 1'b0; burst_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
          do_cycle(); cyc++;
        end
      end
      resp_cnt += int'(resp); wr_cnt += int'(burst_write);
      burst_resp = 1'b1; burst_rdata = line[BW*k +: BW];
      do_cycle(); cyc++;
    end
    burst_resp = 1'b0; read = 1'b0; write = 1'b0;
    check({tag, " early resp"}, LW'(resp_cnt), LW'(0));
    check({tag, " burst_write seen"}, LW'(wr_cnt), LW'(0));
    check({tag, " resp"}, LW'(resp), LW'(1));
    check({tag, " resp cycle"}, LW'(cyc), LW'(6 + nwaits));
    check({tag, " rdata"}, rdata, line);
    do_cycle();
    check({tag, " resp after"}, LW'(resp), LW'(0));
    check({tag, " idle burst_read"}, LW'(burst_read), LW'(0));
  endtask

  task automatic run_write(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_addr, input logic [LW-1:0] line,
                           input int wait_beat, input int nwaits);
    int wr_cnt = 0;
    int resp_cnt = 0;
    write = 1'b1; address = addr; wdata = line; burst_resp = 1'b0;
    do_cycle();
    check({tag, " burst_address"}, LW'(burst_address), LW'(exp_addr));
    // Scramble the request inputs: they must be ignored mid-burst.
    address = 32'hFFFF_FFFF; wdata = '1;
    for (int k = 0; k < 4; k++) begin
      if (k == wait_beat) begin
        for (int w = 0; w < nwaits; w++) begin
          check($sformatf("%s wdata beat%0d wait%0d", tag, k, w),
                LW'(burst_wdata), LW'(line[BW*k +: BW]));
          wr_cnt += int'(burst_write); resp_cnt += int'(resp);
          burst_resp = 1'b0;
          do_cycle();
        end
      end
      check($sformatf("%s wdata beat%0d", tag, k), LW'(burst_wdata),
            LW'(line[BW*k +: BW]));
      wr_cnt += int'(burst_write); resp_cnt += int'(resp);
      burst_resp = 1'b1;
      do_cycle();
    end
    burst_resp = 1'b0; write = 1'b0;
    check({tag, " burst_write cycles"}, LW'(wr_cnt), LW'(4 + nwaits));
    check({tag, " early resp"}, LW'(resp_cnt), LW'(0));
    check({tag, " resp"}, LW'(resp), LW'(1));
    check({tag, " done burst_write"}, LW'(burst_write), LW'(0));
    do_cycle();
    check({tag, " resp after"}, LW'(resp), LW'(0));
  endtask

  localparam logic [LW-1:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [LW-1:0] LINE_W = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                      64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
  localparam logic [LW-1:0] LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'hA5A5_0000_5A5A_FFFF, 64'h1357_9BDF_2468_ACE0};
  localparam logic [LW-1:0] LINE_C = {64'hC4C4_C4C4_0000_0001, 64'hC3C3_C3C3_0000_0002,
                                      64'hC2C2_C2C2_0000_0003, 64'hC1C1_C1C1_0000_0004};
  localparam logic [LW-1:0] LINE_E = {64'hE4E4_1111_2222_3333, 64'hE3E3_4444_5555_6666,
                                      64'hE2E2_7777_8888_9999, 64'hE1E1_AAAA_BBBB_CCCC};

  initial begin
    rst_n = 1'b0; address = 32'h0; read = 1'b1; write = 1'b0; wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;

    // 1. Reset held two cycles with read asserted.
    do_cycle(); do_cycle();
    check("reset resp", LW'(resp), LW'(0));
    check("reset burst_read", LW'(burst_read), LW'(0));
    check("reset burst_write", LW'(burst_write), LW'(0));
    check("reset rdata", rdata, '0);
    check("reset burst_address", LW'(burst_address), LW'(0));
    check("reset burst_wdata", LW'(burst_wdata), LW'(0));
    read = 1'b0; rst_n = 1'b1;
    do_cycle();
    check("post-reset idle", LW'(burst_read), LW'(0));

    // 2. Plain line read, no waits.
    run_read("rd1", 32'h0000_1234, 32'h0000_1220, LINE_A, 0, 0, 1'b0);

    // 3. Write with two waits before beat 2; rdata must survive it.
    run_write("wr1", 32'h8000_00E0, 32'h8000_00E0, LINE_W, 2, 2);
    check("rdata after write", rdata, LINE_A);

    // 4. read+write together: read wins, one wait before beat 1.
    run_read("rdwr", 32'h0000_4F7F, 32'h0000_4F60, LINE_B, 1, 1, 1'b1);

    // 5. Reset after beat 1 of a read, then a fresh read of the same line.
    read = 1'b1; address = 32'h0000_0040;
    do_cycle();
    for (int k = 0; k < 2; k++) begin
      burst_resp = 1'b1; burst_rdata = LINE_E[BW*k +: BW];
      do_cycle();
    end
    burst_resp = 1'b0; read = 1'b0; rst_n = 1'b0;
    do_cycle();
    check("abort burst_read", LW'(burst_read), LW'(0));
    check("abort resp", LW'(resp), LW'(0));
    check("abort rdata", rdata, '0);
    rst_n = 1'b1;
    do_cycle();
    check("abort idle resp", LW'(resp), LW'(0));
    run_read("rd_fresh", 32'h0000_0040, 32'h0000_0040, LINE_C, 0, 0, 1'b0);

    // 6. Write, then a read raised in the IDLE cycle right after resp.
    run_write("wr2", 32'h0000_2000, 32'h0000_2000, LINE_B, 4, 0);
    run_read("rd_b2b", 32'h0000_2008, 32'h0000_2000, LINE_E, 3, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
